fpga_vme_responder: RTL and testbench

FPGA-side responder for the CPLD-to-FPGA register access link. It receives the asynchronous read/write strobes and the 5-bit word address from the CPLD, synchronises them to SYSCLK, and runs a single-beat access on a local register bus. It returns FDTACK to the CPLD, which forwards it unchanged to VME. It sits at the FPGA top level, between the CPLD pins and the register file.

---
 rtl/fpga_vme_responder_pkg.sv | 20 ++
 rtl/fpga_vme_responder_strobe_sync.sv | 25 ++
 rtl/fpga_vme_responder.sv | 141 ++++++++++++++
 tb/tb_fpga_vme_responder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_vme_responder_pkg.sv
// Shared types and constants for the CPLD-to-FPGA register access responder.
package fpga_vme_responder_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 10;

  localparam int unsigned        TIMEOUT_DEF = 255;
  localparam logic [DATA_W-1:0]  TO_DATA_DEF = 32'hFFFF_FFFF;

  localparam logic [CNT_W-1:0]   CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ARM  = 2'd0,
    IDLE = 2'd1,
    WAIT = 2'd2,
    ACK  = 2'd3
  } rsp_state_t;

endpackage

// File: rtl/fpga_vme_responder_strobe_sync.sv
// Two-flop synchroniser for one CPLD strobe into the SYSCLK domain.
module strobe_sync (
  input  logic SYSCLK,
  input  logic RST,
  input  logic async_in,
  output logic sync_out
);

  logic s1;
  logic s2;

  // Capture the asynchronous strobe through two flops; both clear on reset.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
    end
  end

  assign sync_out = s2;

endmodule

// File: rtl/fpga_vme_responder.sv
// FPGA-side responder: turns synchronised CPLD strobes into single-beat
// local register bus accesses and returns FDTACK (active-low) to the CPLD.
//
// state | meaning
// ------+------------------------------------------------------------
// ARM   | after reset; wait for sync pipeline to refill and both strobes low
// IDLE  | ready; exactly one strobe high starts an access
// WAIT  | local pulse issued; wait for LACK or timeout
// ACK   | FDTACK low (DOE high on reads) until the active strobe drops
module fpga_vme_responder
  import fpga_vme_responder_pkg::*;
#(
  parameter int unsigned       TIMEOUT = TIMEOUT_DEF,
  parameter logic [DATA_W-1:0] TO_DATA = TO_DATA_DEF
) (
  input  logic              SYSCLK,
  input  logic              RST,
  input  logic              FWS,
  input  logic              FRS,
  input  logic [ADDR_W-1:0] FA,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DOUT,
  output logic              DOE,
  output logic              FDTACK,
  output logic [ADDR_W-1:0] LADDR,
  output logic [DATA_W-1:0] LWDATA,
  output logic              LWE,
  output logic              LRE,
  input  logic [DATA_W-1:0] LRDATA,
  input  logic              LACK,
  output logic              TOFLAG
);

  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

  rsp_state_t       state;
  rsp_state_t       state_nxt;
  logic             ws_s;
  logic             rs_s;
  logic             is_read;
  logic [CNT_W-1:0] tcnt;
  logic [1:0]       settle_cnt;
  logic             settle_done;
  logic             wr_start;
  logic             rd_start;
  logic             lack_done;
  logic             to_done;

  strobe_sync u_sync_ws (
    .SYSCLK   (SYSCLK),
    .RST      (RST),
    .async_in (FWS),
    .sync_out (ws_s)
  );

  strobe_sync u_sync_rs (
    .SYSCLK   (SYSCLK),
    .RST      (RST),
    .async_in (FRS),
    .sync_out (rs_s)
  );

  // The synchronisers clear on reset, so their outputs read low for two
  // edges even if a strobe is held high. ARM ignores them until they have
  // refilled, otherwise a strobe held through reset would start an access.
  assign settle_done = (settle_cnt == 2'd2);

  // Next-state decode and FDTACK/DOE generation.
  always_comb begin
    state_nxt = state;
    wr_start  = 1'b0;
    rd_start  = 1'b0;
    lack_done = 1'b0;
    to_done   = 1'b0;
    FDTACK    = 1'b1;
    DOE       = 1'b0;
    case (state)
      ARM: begin
        if (settle_done && !ws_s && !rs_s) state_nxt = IDLE;
      end
      IDLE: begin
        // Both strobes high is illegal and simply ignored.
        if (ws_s ^ rs_s) begin
          state_nxt = WAIT;
          wr_start  = ws_s;
          rd_start  = rs_s;
        end
      end
      WAIT: begin
        if (LACK) begin
          lack_done = 1'b1;
          state_nxt = ACK;
        end else if (tcnt == TO_LAST) begin
          to_done   = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        FDTACK = 1'b0;
        DOE    = is_read;
        if (!(is_read ? rs_s : ws_s)) state_nxt = IDLE;
      end
      default: state_nxt = ARM;
    endcase
  end

  // State register, local bus pulses, latches and the timeout counter.
  always_ff @(posedge SYSCLK) begin
    if (RST) begin
      state      <= ARM;
      settle_cnt <= 2'd0;
      is_read    <= 1'b0;
      tcnt       <= '0;
      LWE        <= 1'b0;
      LRE        <= 1'b0;
      LADDR      <= '0;
      LWDATA     <= '0;
      DOUT       <= '0;
      TOFLAG     <= 1'b0;
    end else begin
      state <= state_nxt;
      LWE   <= wr_start;
      LRE   <= rd_start;
      if (state == ARM && !settle_done) settle_cnt <= settle_cnt + 2'd1;
      if (wr_start || rd_start) begin
        LADDR   <= FA;
        is_read <= rd_start;
        tcnt    <= '0;
      end else if (state == WAIT && tcnt != CNT_MAX) begin
        tcnt <= tcnt + 1'b1;
      end
      if (wr_start) LWDATA <= DIN;
      if (lack_done && is_read) DOUT <= LRDATA;
      if (to_done) begin
        TOFLAG <= 1'b1;
        if (is_read) DOUT <= TO_DATA;
      end
    end
  end

endmodule

// File: tb/tb_fpga_vme_responder.sv
// Self-checking bench for fpga_vme_responder with a local register-file model.
module tb_fpga_vme_responder;
  import fpga_vme_responder_pkg::*;

  localparam int TO_CYC = 8;

  logic        SYSCLK = 1'b0;
  logic        RST;
  logic        FWS;
  logic        FRS;
  logic [4:0]  FA;
  logic [31:0] DIN;
  logic [31:0] DOUT;
  logic        DOE;
  logic        FDTACK;
  logic [4:0]  LADDR;
  logic [31:0] LWDATA;
  logic        LWE;
  logic        LRE;
  logic [31:0] LRDATA;
  logic        LACK;
  logic        TOFLAG;

  typedef struct {
    bit          rd;
    logic [4:0]  addr;
    logic [31:0] data;
    int          lat;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] smem[32];
  logic [31:0] model[32];
  int          wait_n = 0;
  logic        lack_q = 1'b0;
  logic [31:0] rdata_q = '0;
  int          wr_pulses = 0;
  int          rd_pulses = 0;
  logic [4:0]  last_waddr = '0;
  logic [31:0] last_wdata = '0;
  int          n_checks = 0;
  int          n_fail = 0;

  always #15 SYSCLK = ~SYSCLK;

  fpga_vme_responder #(.TIMEOUT(TO_CYC)) dut (
    .SYSCLK (SYSCLK),
    .RST    (RST),
    .FWS    (FWS),
    .FRS    (FRS),
    .FA     (FA),
    .DIN    (DIN),
    .DOUT   (DOUT),
    .DOE    (DOE),
    .FDTACK (FDTACK),
    .LADDR  (LADDR),
    .LWDATA (LWDATA),
    .LWE    (LWE),
    .LRE    (LRE),
    .LRDATA (LRDATA),
    .LACK   (LACK),
    .TOFLAG (TOFLAG)
  );

  // Zero-wait slave answers in the same cycle as the pulse.
  assign LACK   = (wait_n == 0) ? (LWE | LRE) : lack_q;
  assign LRDATA = (wait_n == 0) ? smem[LADDR] : rdata_q;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Local register file: record pulses and store writes.
  initial forever begin
    @(posedge SYSCLK); #1;
    if (LWE === 1'b1) begin
      wr_pulses++;
      last_waddr = LADDR;
      last_wdata = LWDATA;
      smem[LADDR] = LWDATA;
    end
    if (LRE === 1'b1) rd_pulses++;
  end

  // Delayed acknowledge for accesses with wait states; negative means never.
  initial forever begin
    @(posedge SYSCLK); #1;
    if ((LWE === 1'b1 || LRE === 1'b1) && wait_n > 0) begin
      repeat (wait_n) begin @(posedge SYSCLK); #1; end
      lack_q  = 1'b1;
      rdata_q = smem[LADDR];
      @(posedge SYSCLK); #1;
      lack_q  = 1'b0;
    end
  end

  task automatic do_access(input bit rd, input logic [4:0] addr, input logic [31:0] data,
                           input int waits);
    exp_t e;
    int   cnt;
    int   wr0;
    int   rd0;
    e.rd   = rd;
    e.addr = addr;
    e.lat  = (waits < 0) ? 3 + TO_CYC : 4 + waits;
    if (rd) e.data = (waits < 0) ? 32'hFFFF_FFFF : model[addr];
    else begin
      e.data      = data;
      model[addr] = data;
    end
    sbq.push_back(e);
    wr0    = wr_pulses;
    rd0    = rd_pulses;
    wait_n = waits;
    FA     = addr;
    DIN    = data;
    if (rd) FRS = 1'b1; else FWS = 1'b1;
    cnt = 0;
    while (FDTACK !== 1'b0 && cnt < 100) begin @(posedge SYSCLK); #1; cnt++; end
    e = sbq.pop_front();
    check("ack_latency", cnt, e.lat);
    if (e.rd) begin
      check("rd_data", DOUT, e.data);
      check("rd_doe", 32'(DOE), 32'd1);
      check("rd_pulses", rd_pulses - rd0, 1);
    end else begin
      check("wr_addr", 32'(last_waddr), 32'(e.addr));
      check("wr_data", last_wdata, e.data);
      check("wr_pulses", wr_pulses - wr0, 1);
      check("wr_doe", 32'(DOE), 32'd0);
    end
    FWS = 1'b0;
    FRS = 1'b0;
    cnt = 0;
    while (FDTACK !== 1'b1 && cnt < 100) begin @(posedge SYSCLK); #1; cnt++; end
    check("release_latency", cnt, 3);
    check("release_doe", 32'(DOE), 32'd0);
  endtask

  initial begin
    logic [31:0] v;
    int          wr0;
    int          rd0;
    bit          saw_ack;
    int          cnt;
    for (int i = 0; i < 32; i++) begin
      v        = $urandom;
      smem[i]  = v;
      model[i] = v;
    end
    smem[31]  = 32'hCAFE_F00D;
    model[31] = 32'hCAFE_F00D;
    RST = 1'b1; FWS = 1'b0; FRS = 1'b0; FA = '0; DIN = '0;

    repeat (3) @(posedge SYSCLK);
    #1;
    check("rst_fdtack", 32'(FDTACK), 32'd1);
    check("rst_doe", 32'(DOE), 32'd0);
    check("rst_lwe", 32'(LWE), 32'd0);
    check("rst_lre", 32'(LRE), 32'd0);
    check("rst_dout", DOUT, 32'd0);
    check("rst_laddr", 32'(LADDR), 32'd0);
    check("rst_lwdata", LWDATA, 32'd0);
    check("rst_toflag", 32'(TOFLAG), 32'd0);
    RST = 1'b0;
    repeat (5) begin @(posedge SYSCLK); #1; end

    // Zero-wait write, then 4-wait read of the top address.
    do_access(1'b0, 5'h03, 32'h1234_5678, 0);
    do_access(1'b1, 5'h1F, 32'h0, 4);
    do_access(1'b1, 5'h03, 32'h0, 0);

    // Timeout read: no LACK ever.
    check("toflag_before", 32'(TOFLAG), 32'd0);
    do_access(1'b1, 5'h05, 32'h0, -1);
    check("toflag_set", 32'(TOFLAG), 32'd1);
    do_access(1'b0, 5'h05, 32'hA5A5_0001, 2);
    check("toflag_sticky", 32'(TOFLAG), 32'd1);

    // Both strobes together: ignored.
    wait_n = 0; wr0 = wr_pulses; rd0 = rd_pulses; saw_ack = 1'b0;
    FA = 5'h07; DIN = 32'hDEAD_BEEF; FWS = 1'b1; FRS = 1'b1;
    repeat (10) begin @(posedge SYSCLK); #1; if (FDTACK !== 1'b1) saw_ack = 1'b1; end
    check("illegal_ack", 32'(saw_ack), 32'd0);
    check("illegal_pulses", (wr_pulses - wr0) + (rd_pulses - rd0), 0);
    FWS = 1'b0; FRS = 1'b0;
    repeat (3) begin @(posedge SYSCLK); #1; end
    do_access(1'b0, 5'h07, 32'h0BAD_CAFE, 1);

    // Reset while in ACK with FRS held high.
    wait_n = 0; FA = 5'h02; FRS = 1'b1; cnt = 0;
    while (FDTACK !== 1'b0 && cnt < 100) begin @(posedge SYSCLK); #1; cnt++; end
    check("mid_rst_reach_ack", cnt, 4);
    RST = 1'b1;
    @(posedge SYSCLK); #1;
    check("mid_rst_fdtack", 32'(FDTACK), 32'd1);
    check("mid_rst_doe", 32'(DOE), 32'd0);
    check("mid_rst_toflag", 32'(TOFLAG), 32'd0);
    RST = 1'b0; rd0 = rd_pulses; saw_ack = 1'b0;
    repeat (10) begin @(posedge SYSCLK); #1; if (FDTACK !== 1'b1) saw_ack = 1'b1; end
    check("held_strobe_ack", 32'(saw_ack), 32'd0);
    check("held_strobe_pulses", rd_pulses - rd0, 0);
    FRS = 1'b0;
    repeat (3) begin @(posedge SYSCLK); #1; end
    do_access(1'b1, 5'h02, 32'h0, 0);

    // Random back-to-back traffic against the address model.
    for (int k = 0; k < 100; k++) begin
      do_access(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                int'($urandom_range(0, 5)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
